decade_timer_ctrl: RTL



---
 rtl/decade_timer_pkg.sv | 18 +
 rtl/decade_timer_ctrl_if.sv | 21 ++
 rtl/bcd_digit_dn.sv | 28 ++
 rtl/decade_timer_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/decade_timer_pkg.sv
// Shared types and helpers for the decade countdown timer.
// Optional periodic mode: DECADE_TIMER_AUTO_RELOAD_EN (see decade_timer_ctrl).
package decade_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HOLD,
        ST_DONE
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic bcd_valid(input logic [3:0] nibble);
        return nibble <= BCD_MAX;
    endfunction

endpackage

// File: rtl/decade_timer_ctrl_if.sv
// Preset load handshake between the register interface and the timer.
// Macro DECADE_TIMER_AUTO_RELOAD_EN does not affect this interface.
interface decade_timer_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  load_valid;
    logic                  load_ready;
    logic [4*DIGITS-1:0]   load_bcd;

    modport master (
        output load_valid,
        output load_bcd,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_bcd,
        output load_ready
    );
endinterface

// File: rtl/bcd_digit_dn.sv
// One BCD down-counting digit with parallel load and borrow chaining.
// Macro DECADE_TIMER_AUTO_RELOAD_EN does not affect this module.
module bcd_digit_dn
    import decade_timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       borrow_in,
    output logic [3:0] value,
    output logic       borrow_out
);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (borrow_in) begin
            value <= (value == 4'd0) ? BCD_MAX : value - 4'd1;
        end
    end

    // Borrow ripples combinationally so the whole chain settles in one cycle.
    assign borrow_out = borrow_in && (value == 4'd0);

endmodule

// File: rtl/decade_timer_ctrl.sv
// Countdown timer controller over a chain of BCD digits, single clock.
// Define DECADE_TIMER_AUTO_RELOAD_EN for periodic reload on terminal count.
module decade_timer_ctrl
    import decade_timer_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                tick,
    decade_timer_ctrl_if.slave  load,
    output logic [4*DIGITS-1:0] count,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int W = 4 * DIGITS;
    localparam logic [W-1:0] ONE = W'(1);

    state_t         state;
    state_t         state_nxt;
    logic           bcd_ok;
    logic           load_accept;
    logic           load_reject;
    logic           dig_load;
    logic           dec_en;
    logic           done_nxt;
    logic           err_nxt;
    logic [W-1:0]   dig_load_val;
    logic [W-1:0]   start_val;
    logic [DIGITS:0] borrow;

    assign load.load_ready = (state == ST_IDLE) || (state == ST_DONE);

    always_comb begin
        bcd_ok = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (!bcd_valid(load.load_bcd[4*i +: 4])) begin
                bcd_ok = 1'b0;
            end
        end
    end

    assign load_accept = load.load_ready && load.load_valid && bcd_ok;
    assign load_reject = load.load_ready && load.load_valid && !bcd_ok;
    // A start in the same cycle as an accepted load sees the new preset.
    assign start_val   = load_accept ? load.load_bcd : count;

`ifdef DECADE_TIMER_AUTO_RELOAD_EN
    logic [W-1:0] reload;

    always_ff @(posedge clk) begin
        if (rst) begin
            reload <= '0;
        end else if (load_accept) begin
            reload <= load.load_bcd;
        end
    end
`endif

    always_comb begin
        state_nxt    = state;
        dig_load     = 1'b0;
        dig_load_val = load.load_bcd;
        dec_en       = 1'b0;
        done_nxt     = 1'b0;
        err_nxt      = load_reject;

        unique case (state)
            ST_IDLE: begin
                dig_load = load_accept;
                if (!stop && start) begin
                    if (start_val != '0) begin
                        state_nxt = ST_RUN;
                    end else begin
                        state_nxt = ST_DONE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_nxt = ST_HOLD;
                end else if (tick) begin
                    if (count == ONE) begin
`ifdef DECADE_TIMER_AUTO_RELOAD_EN
                        if (reload != '0) begin
                            dig_load     = 1'b1;
                            dig_load_val = reload;
                            done_nxt     = 1'b1;
                        end else begin
                            dec_en    = 1'b1;
                            state_nxt = ST_DONE;
                            done_nxt  = 1'b1;
                        end
`else
                        dec_en    = 1'b1;
                        state_nxt = ST_DONE;
                        done_nxt  = 1'b1;
`endif
                    end else begin
                        dec_en = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else if (start) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_DONE: begin
                dig_load  = load_accept;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            done  <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
            err   <= err_nxt;
            busy  <= (state_nxt == ST_RUN) || (state_nxt == ST_HOLD);
        end
    end

    assign borrow[0] = dec_en;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_dn u_digit (
            .clk        (clk),
            .rst        (rst),
            .load       (dig_load),
            .load_val   (dig_load_val[4*g +: 4]),
            .borrow_in  (borrow[g]),
            .value      (count[4*g +: 4]),
            .borrow_out (borrow[g+1])
        );
    end

    // RUN never holds zero, so the chain must never borrow past the top digit.
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) !borrow[DIGITS]);

endmodule
